// File: rtl/keypad_digit_display_if.sv
// Keypad-to-display bus: scanner strobe/row/column in, display drive out.
// Ports: new_key, row_pwr[3:0], cols_newkey[3:0] (scanner side drives);
//        seg[6:0], an[1:0], digit_new[3:0], digit_old[3:0], key_err (display side drives).
interface keypad_digit_display_if;
    logic       new_key;
    logic [3:0] row_pwr;
    logic [3:0] cols_newkey;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_err;

    modport master (
        output new_key, row_pwr, cols_newkey,
        input  seg, an, digit_new, digit_old, key_err
    );

    modport slave (
        input  new_key, row_pwr, cols_newkey,
        output seg, an, digit_new, digit_old, key_err
    );
endinterface

// File: rtl/keypad_digit_display.sv
// Decodes keypad strobes to hex digits, keeps the last two, and multiplexes
// them onto a dual common-anode 7-seg display with blanking between digits.
// Ports: clk, reset (sync, active-low), bus (slave modport of keypad_digit_display_if).
module keypad_digit_display #(
    parameter int MUX_DIV      = 48000,
    parameter int BLANK_CYCLES = 480,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_digit_display_if.slave bus
);

    typedef enum logic [1:0] {
        SHOW_R,
        BLANK_RL,
        SHOW_L,
        BLANK_LR
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(MUX_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       an_q;
    logic [1:0]       an_nxt;
    logic [6:0]       seg_q;
    logic [6:0]       seg_nxt;
    logic [3:0]       d_new;
    logic [3:0]       d_old;
    logic [1:0]       valid;
    logic             nk_q;
    logic             err_q;
    logic             accept;
    logic             pair_ok;
    logic [3:0]       dec;

    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Only meaningful when both vectors are one-hot; other codes fall to 0.
    function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] v;
        case ({r, c})
            8'b0001_0001: v = 4'h1;
            8'b0001_0010: v = 4'h2;
            8'b0001_0100: v = 4'h3;
            8'b0001_1000: v = 4'hA;
            8'b0010_0001: v = 4'h4;
            8'b0010_0010: v = 4'h5;
            8'b0010_0100: v = 4'h6;
            8'b0010_1000: v = 4'hB;
            8'b0100_0001: v = 4'h7;
            8'b0100_0010: v = 4'h8;
            8'b0100_0100: v = 4'h9;
            8'b0100_1000: v = 4'hC;
            8'b1000_0001: v = 4'hE;
            8'b1000_0010: v = 4'h0;
            8'b1000_0100: v = 4'hF;
            8'b1000_1000: v = 4'hD;
            default:      v = 4'h0;
        endcase
        return v;
    endfunction

    assign accept  = bus.new_key && !nk_q;
    assign pair_ok = $onehot(bus.row_pwr) && $onehot(bus.cols_newkey);
    assign dec     = decode(bus.row_pwr, bus.cols_newkey);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        an_nxt    = 2'b11;
        seg_nxt   = SEG_OFF;
        unique case (state)
            SHOW_R: begin
                an_nxt  = 2'b10;
                seg_nxt = valid[0] ? font(d_new) : SEG_OFF;
                if (cnt == SHOW_LAST) begin
                    state_nxt = BLANK_RL;
                    cnt_nxt   = '0;
                end
            end
            BLANK_RL: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW_L;
                    cnt_nxt   = '0;
                end
            end
            SHOW_L: begin
                an_nxt  = 2'b01;
                seg_nxt = valid[1] ? font(d_old) : SEG_OFF;
                if (cnt == SHOW_LAST) begin
                    state_nxt = BLANK_LR;
                    cnt_nxt   = '0;
                end
            end
            BLANK_LR: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW_R;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SHOW_R;
            cnt   <= '0;
            an_q  <= 2'b11;
            seg_q <= SEG_OFF;
            d_new <= 4'h0;
            d_old <= 4'h0;
            valid <= 2'b00;
            nk_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            nk_q  <= bus.new_key;
            err_q <= accept && !pair_ok;
            if (accept && pair_ok) begin
                d_old <= d_new;
                d_new <= dec;
                valid <= {valid[0], 1'b1};
            end
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_new = d_new;
    assign bus.digit_old = d_old;
    assign bus.key_err   = err_q;

endmodule

// File: tb/tb_keypad_digit_display.sv
// Randomized + directed bench for keypad_digit_display against a
// cycle-indexed reference model (digit history queue, schedule by modulo).
module tb_keypad_digit_display;

    localparam int MUX    = 8;
    localparam int BLANK  = 2;
    localparam int PERIOD = 2 * (MUX + BLANK);

    logic clk;
    logic reset;

    keypad_digit_display_if bus ();

    keypad_digit_display #(
        .MUX_DIV     (MUX),
        .BLANK_CYCLES(BLANK),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] font_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};
    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                          '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    int         hist[$];
    int         k;
    bit         m_nkq;
    logic [1:0] m_an;
    logic [6:0] m_seg;
    logic       m_err;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_new();
        return hist.size() > 0 ? hist[hist.size()-1] : 0;
    endfunction

    function automatic int m_old();
        return hist.size() > 1 ? hist[hist.size()-2] : 0;
    endfunction

    function automatic int idx1h(logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Model one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        int p;
        if (!reset) begin
            hist.delete();
            k     = 0;
            m_nkq = 0;
            m_an  = 2'b11;
            m_seg = 7'h7F;
            m_err = 0;
        end else begin
            p = k % PERIOD;
            m_an  = 2'b11;
            m_seg = 7'h7F;
            if (p < MUX) begin
                m_an = 2'b10;
                if (hist.size() >= 1) m_seg = font_t[m_new()];
            end else if (p >= MUX + BLANK && p < 2 * MUX + BLANK) begin
                m_an = 2'b01;
                if (hist.size() >= 2) m_seg = font_t[m_old()];
            end
            k++;
            m_err = 0;
            if (bus.new_key && !m_nkq) begin
                if ($countones(bus.row_pwr) == 1 &&
                    $countones(bus.cols_newkey) == 1) begin
                    hist.push_back(keymap[idx1h(bus.row_pwr)][idx1h(bus.cols_newkey)]);
                    if (hist.size() > 2) void'(hist.pop_front());
                end else begin
                    m_err = 1;
                end
            end
            m_nkq = bus.new_key;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("an", bus.an, m_an);
        chk("seg", bus.seg, m_seg);
        chk("digit_new", bus.digit_new, m_new());
        chk("digit_old", bus.digit_old, m_old());
        chk("key_err", bus.key_err, m_err);
        chk("an_not_00", bus.an != 2'b00, 1);
    endtask

    task automatic idle(int n);
        bus.new_key = 0;
        repeat (n) step();
    endtask

    task automatic strobe(logic [3:0] r, logic [3:0] c, int len);
        bus.row_pwr     = r;
        bus.cols_newkey = c;
        bus.new_key     = 1;
        repeat (len) step();
        bus.new_key = 0;
        step();
    endtask

    function automatic logic [3:0] rand_vec();
        if ($urandom_range(0, 3) != 0) return 4'(1 << $urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        bit in_l;
        reset           = 0;
        bus.new_key     = 0;
        bus.row_pwr     = 4'b0000;
        bus.cols_newkey = 4'b0000;
        repeat (3) step();
        reset = 1;
        idle(40);

        strobe(4'b0001, 4'b0100, 1);
        idle(22);
        strobe(4'b0010, 4'b0001, 1);
        strobe(4'b1000, 4'b0010, 1);
        idle(22);
        chk("old_is_4", bus.digit_old, 4);
        chk("new_is_0", bus.digit_new, 0);
        strobe(4'b1000, 4'b1000, 1);
        idle(12);
        chk("new_is_d", bus.digit_new, 4'hD);
        strobe(4'b0100, 4'b0100, 5);
        chk("held_new_9", bus.digit_new, 9);
        chk("held_old_d", bus.digit_old, 4'hD);
        idle(3);
        strobe(4'b0010, 4'b0110, 1);
        idle(2);
        strobe(4'b0000, 4'b0001, 1);
        idle(2);
        chk("err_keep_new", bus.digit_new, 9);

        in_l = 0;
        for (int i = 0; i < 40 && !in_l; i++) begin
            step();
            in_l = (k % PERIOD) >= MUX + BLANK + 1 &&
                   (k % PERIOD) < 2 * MUX + BLANK;
        end
        chk("reach_show_l", in_l, 1);
        reset           = 0;
        bus.row_pwr     = 4'b0001;
        bus.cols_newkey = 4'b0001;
        bus.new_key     = 1;
        step();
        chk("rst_an", bus.an, 2'b11);
        chk("rst_new", bus.digit_new, 0);
        bus.new_key = 0;
        step();
        reset = 1;
        idle(25);

        for (int i = 0; i < 800; i++) begin
            bus.new_key     = ($urandom_range(0, 4) == 0);
            bus.row_pwr     = rand_vec();
            bus.cols_newkey = rand_vec();
            if ($urandom_range(0, 299) == 0) reset = 0;
            else reset = 1;
            step();
        end
        reset = 1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
